// File: rtl/gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter.sv
// Ring-oscillator frequency meter.
// Synchronises the asynchronous RO_IN, then counts its rising edges over a
// programmable window of CLK cycles and reports a saturating count with a
// one-cycle DONE pulse. All outputs are registered.
module gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter #(
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RO_IN,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rs_d_q, rs_d_d;
  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rs_c;
  logic                   rise_c;

  // Synchroniser shift and edge detection; rs_d simply trails rs every cycle,
  // so the ARM cycle flushes any edge that predates the window.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], RO_IN};
    rs_c   = sync_q[SYNC_STAGES-1];
    rs_d_d = rs_c;
    rise_c = rs_c & ~rs_d_q;
  end

  // Synchroniser and edge-detect registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      rs_d_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rs_d_q <= rs_d_d;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (win_cnt_q == '0) state_d = ST_DONE;
        else                 state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (win_cnt_q == WIN_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values: window countdown, saturating edge count
  always_comb begin
    win_cnt_d = win_cnt_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (START) win_cnt_d = WIN;
      end
      ST_ARM: begin
        count_d = '0;
        ovf_d   = 1'b0;
      end
      ST_COUNT: begin
        win_cnt_d = win_cnt_q - WIN_W'(1);
        if (rise_c) begin
          if (count_q == CNT_MAX) ovf_d   = 1'b1;
          else                    count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_cnt_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign COUNT = count_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter.sv
// Bench for the ring-oscillator frequency meter: directed table, hand-written
// corner sequences and randomized RO waveforms checked against an edge-count model.
module tb_gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter;

  localparam int SYNC = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RO_IN;
  logic        START;
  logic [15:0] WIN;
  logic        BUSY, DONE, OVF;
  logic [15:0] COUNT;
  logic        BUSY_S, DONE_S, OVF_S;
  logic [3:0]  COUNT_S;

  int n_tests = 0;
  int n_fail  = 0;

  gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter #(.WIN_W(16), .CNT_W(16), .SYNC_STAGES(SYNC)) u_dut (
    .CLK(CLK), .RST(RST), .RO_IN(RO_IN), .START(START), .WIN(WIN),
    .BUSY(BUSY), .DONE(DONE), .COUNT(COUNT), .OVF(OVF)
  );

  gf180mcu_fd_sc_mcu9t5v0__ro_freq_meter #(.WIN_W(16), .CNT_W(4), .SYNC_STAGES(SYNC)) u_dut_s (
    .CLK(CLK), .RST(RST), .RO_IN(RO_IN), .START(START), .WIN(WIN),
    .BUSY(BUSY_S), .DONE(DONE_S), .COUNT(COUNT_S), .OVF(OVF_S)
  );

  always #5 CLK = ~CLK;

  // Sampled RO_IN history (0 while in reset), indexed by rising-edge number
  bit ro_hist [0:65535];
  int cyc = 0;
  always @(posedge CLK) begin
    ro_hist[cyc] <= RST ? 1'b0 : RO_IN;
    cyc          <= cyc + 1;
  end

  // RO_IN generator: 0 stuck, 1 periodic, 2 random half-periods of 3..7 cycles
  int ro_mode   = 0;
  bit ro_level  = 1'b0;
  int ro_period = 8;
  initial begin
    int ph;
    int hold;
    ph = 0;
    hold = 3;
    RO_IN = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      case (ro_mode)
        0: RO_IN = ro_level;
        1: begin
          RO_IN = (ph < ro_period / 2);
          ph = (ph + 1) % ro_period;
        end
        default: begin
          if (hold <= 0) begin
            RO_IN = ~RO_IN;
            hold = $urandom_range(3, 7);
          end
          hold--;
        end
      endcase
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: rising transitions of the sampled waveform inside the window,
  // shifted by the synchroniser latency. Window opens the cycle after ARM.
  function automatic int model_edges(input int n, input int win);
    int c;
    c = 0;
    for (int j = n + 2 - SYNC; j <= n + win + 1 - SYNC; j++)
      if (ro_hist[j] && !ro_hist[j-1]) c++;
    return c;
  endfunction

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Wait for DONE with a cycle budget; d = edge number that raised it, or -1
  task automatic wait_done(input int budget, output int d);
    int k;
    k = 0;
    while (!DONE && k < budget) begin
      @(posedge CLK); #1;
      k++;
    end
    d = DONE ? cyc - 1 : -1;
  endtask

  // One measurement from IDLE: pulse START, scramble WIN after capture,
  // check DONE latency, BUSY throughout, and that DONE is a single pulse.
  task automatic run_meas(input int win, input string tag, output int n);
    int  e;
    bit  busy_ok;
    @(posedge CLK); #1;
    WIN = 16'(win);
    START = 1'b1;
    @(posedge CLK); #1;
    n = cyc - 1;
    START = 1'b0;
    WIN = 16'($urandom);
    e = 0;
    busy_ok = 1'b1;
    while (!DONE && e < win + 20) begin
      if (!BUSY) busy_ok = 1'b0;
      @(posedge CLK); #1;
      e++;
    end
    if (!BUSY) busy_ok = 1'b0;
    check({tag, " done_latency"}, DONE ? e : -1, win + 1);
    check({tag, " busy_during"}, busy_ok, 1);
    @(posedge CLK); #1;
    check({tag, " done_pulse_busy_after"}, {DONE, BUSY}, 0);
  endtask

  typedef struct {
    int win;
    int mode;
    int period;
    bit level;
    int exp_cnt;
    int exp_ovf;
    int exp_cnt_s;
    int exp_ovf_s;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n, n2, d1, d2;
    int m;
    tbl[0] = '{80,  1, 8,  1'b0, 10, 0, 10, 0};
    tbl[1] = '{0,   1, 8,  1'b0, 0,  0, 0,  0};
    tbl[2] = '{100, 1, 4,  1'b0, 25, 0, 15, 1};
    tbl[3] = '{50,  0, 8,  1'b1, 0,  0, 0,  0};
    tbl[4] = '{50,  0, 8,  1'b0, 0,  0, 0,  0};
    tbl[5] = '{64,  1, 16, 1'b0, 4,  0, 4,  0};
    tbl[6] = '{15,  1, 5,  1'b0, 3,  0, 3,  0};
    tbl[7] = '{16,  1, 4,  1'b0, 4,  0, 4,  0};
    tbl[8] = '{120, 1, 8,  1'b0, 15, 0, 15, 0};
    tbl[9] = '{128, 1, 8,  1'b0, 16, 0, 15, 1};

    RST = 1'b1;
    START = 1'b0;
    WIN = 16'd0;
    ro_mode = 1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset busy",  BUSY, 0);
    check("reset done",  DONE, 0);
    check("reset count", COUNT, 0);
    check("reset ovf",   OVF, 0);
    check("reset count_s", COUNT_S, 0);
    RST = 1'b0;
    repeat (10) @(posedge CLK);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      ro_mode = tbl[i].mode;
      ro_period = tbl[i].period;
      ro_level = tbl[i].level;
      repeat (12) @(posedge CLK);
      run_meas(tbl[i].win, $sformatf("vec%0d", i), n);
      check($sformatf("vec%0d count", i), COUNT, tbl[i].exp_cnt);
      check($sformatf("vec%0d ovf", i), OVF, tbl[i].exp_ovf);
      check($sformatf("vec%0d count_s", i), COUNT_S, tbl[i].exp_cnt_s);
      check($sformatf("vec%0d ovf_s", i), OVF_S, tbl[i].exp_ovf_s);
      check($sformatf("vec%0d model", i), COUNT, model_edges(n, tbl[i].win));
    end

    // START re-pulsed and WIN changed mid-window: ignored
    ro_mode = 1;
    ro_period = 8;
    repeat (12) @(posedge CLK);
    #1;
    WIN = 16'd20;
    START = 1'b1;
    @(posedge CLK); #1;
    n = cyc - 1;
    START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    WIN = 16'd5;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(40, d1);
    check("repulse done_latency", (d1 < 0) ? -1 : d1 - n, 21);
    check("repulse count", COUNT, model_edges(n, 20));
    repeat (4) @(posedge CLK);
    #1;
    check("repulse not_queued", {BUSY, DONE}, 0);

    // START held high: back-to-back measurements with one IDLE cycle between
    repeat (5) @(posedge CLK);
    #1;
    WIN = 16'd10;
    START = 1'b1;
    @(posedge CLK); #1;
    n = cyc - 1;
    wait_done(30, d1);
    check("b2b first latency", (d1 < 0) ? -1 : d1 - n, 11);
    check("b2b first count", COUNT, model_edges(n, 10));
    @(posedge CLK); #1;
    wait_done(30, d2);
    check("b2b gap", (d1 < 0 || d2 < 0) ? -1 : d2 - d1, 13);
    n2 = d1 + 2;
    check("b2b second count", COUNT, model_edges(n2, 10));
    START = 1'b0;
    repeat (20) @(posedge CLK);

    // Reset mid-window: immediate clear, partial count discarded
    #1;
    WIN = 16'd40;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (12) @(posedge CLK);
    #1;
    check("midrst busy_before", BUSY, 1);
    RST = 1'b1;
    #1;
    check("midrst async clear", {BUSY, DONE, OVF, COUNT}, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("midrst held clear", {BUSY, DONE, OVF, COUNT}, 0);
    RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("midrst idle_after", {BUSY, DONE}, 0);
    run_meas(40, "postrst", n);
    check("postrst count", COUNT, 5);
    check("postrst model", COUNT, model_edges(n, 40));

    // Randomized RO waveforms and window lengths against the model
    ro_mode = 2;
    repeat (12) @(posedge CLK);
    for (int i = 0; i < 12; i++) begin
      int w;
      w = $urandom_range(0, 200);
      run_meas(w, $sformatf("rnd%0d", i), n);
      m = model_edges(n, w);
      check($sformatf("rnd%0d count", i), COUNT, m);
      check($sformatf("rnd%0d ovf", i), OVF, 0);
      check($sformatf("rnd%0d count_s", i), COUNT_S, sat4(m));
      check($sformatf("rnd%0d ovf_s", i), OVF_S, (m > 15) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
